key_debounce: RTL

Input-side companion to the LED blinker. It takes the board's raw pushbutton inputs and produces clean, debounced key levels plus single-cycle press and release pulses, which downstream logic uses to select blink rates and LED patterns. It sits directly behind the FPGA key pins and runs in the 50 MHz `clk` domain.

---
 rtl/key_pkg.sv | 15 +
 rtl/key_debounce_if.sv | 35 +++
 rtl/key_debounce_ch.sv | 141 ++++++++++++++
 rtl/key_debounce.sv | 52 +++++
 4 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared key channel states and 50 MHz timing constants
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_t;

  // Also consumed by the blinker rate tables
  localparam int unsigned CYCLES_20MS = 1_000_000;
  localparam int unsigned CYCLES_1S   = 50_000_000;

endpackage

// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - key pin / debounced event bundle; key_long needs KEY_LONG_PRESS_EN
interface key_debounce_if #(
  parameter int N_KEYS = 4
);

  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;

`ifdef KEY_LONG_PRESS_EN
  logic [N_KEYS-1:0] key_long;

  modport master (
    output key_raw,
    input  key_level, key_press, key_release, key_long
  );

  modport slave (
    input  key_raw,
    output key_level, key_press, key_release, key_long
  );
`else
  modport master (
    output key_raw,
    input  key_level, key_press, key_release
  );

  modport slave (
    input  key_raw,
    output key_level, key_press, key_release
  );
`endif

endinterface

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: 2-FF sync, debounce FSM, optional hold counter
// Hold counter and o_long exist only with KEY_LONG_PRESS_EN.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter bit ACTIVE_LOW      = 1'b1
`ifdef KEY_LONG_PRESS_EN
  ,
  parameter int LONG_CYCLES     = 32
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
`ifdef KEY_LONG_PRESS_EN
  ,
  output logic o_long
`endif
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic PIN_IDLE = ACTIVE_LOW;

  logic       r_sync1;
  logic       r_sync2;
  logic       w_p;
  key_state_t r_state;
  key_state_t w_state_nxt;
  logic [DW-1:0] r_dcnt;
  logic [DW-1:0] w_dcnt_nxt;
  logic       r_press;
  logic       w_press_nxt;
  logic       r_release;
  logic       w_release_nxt;

  assign w_p = ACTIVE_LOW ? ~r_sync2 : r_sync2;

  always_comb begin
    w_state_nxt   = r_state;
    w_dcnt_nxt    = r_dcnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_p) begin
          w_state_nxt = PRESS_CHK;
          w_dcnt_nxt  = '0;
        end
      end
      PRESS_CHK: begin
        if (!w_p) begin
          w_state_nxt = RELEASED;
        end else if (r_dcnt == D_LAST) begin
          w_state_nxt = PRESSED;
          w_press_nxt = 1'b1;
        end else begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!w_p) begin
          w_state_nxt = RELEASE_CHK;
          w_dcnt_nxt  = '0;
        end
      end
      RELEASE_CHK: begin
        if (w_p) begin
          w_state_nxt = PRESSED;
        end else if (r_dcnt == D_LAST) begin
          w_state_nxt   = RELEASED;
          w_release_nxt = 1'b1;
        end else begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end
      default: w_state_nxt = RELEASED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= PIN_IDLE;
      r_sync2   <= PIN_IDLE;
      r_state   <= RELEASED;
      r_dcnt    <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  assign o_level   = (r_state == PRESSED) || (r_state == RELEASE_CHK);
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef KEY_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] r_hcnt;
  logic [LW-1:0] w_hcnt_nxt;
  logic          r_long;
  logic          w_long_nxt;

  // Keeps counting through RELEASE_CHK so a bounce mid-hold keeps its time
  always_comb begin
    w_hcnt_nxt = r_hcnt;
    w_long_nxt = 1'b0;
    if (w_press_nxt) begin
      w_hcnt_nxt = '0;
    end else if (((r_state == PRESSED) || (r_state == RELEASE_CHK)) && (r_hcnt != L_LAST)) begin
      w_hcnt_nxt = r_hcnt + 1'b1;
      w_long_nxt = (w_hcnt_nxt == L_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt <= '0;
      r_long <= 1'b0;
    end else begin
      r_hcnt <= w_hcnt_nxt;
      r_long <= w_long_nxt;
    end
  end

  assign o_long = r_long;
`endif

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - N_KEYS independent debounced key channels
// Optional long-press pulse enabled by KEY_LONG_PRESS_EN.
module key_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = CYCLES_20MS,
  parameter int LONG_CYCLES     = CYCLES_1S,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input logic          clk,
  input logic          rst,
  key_debounce_if.slave bus
);

  // An illegal timing configuration elaborates to a block whose outputs stay low
  localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 2) && (LONG_CYCLES > DEBOUNCE_CYCLES);

  generate
    if (CFG_OK) begin : g_ok
      for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
          .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
          .ACTIVE_LOW     (ACTIVE_LOW)
`ifdef KEY_LONG_PRESS_EN
          ,
          .LONG_CYCLES    (LONG_CYCLES)
`endif
        ) u_ch (
          .clk      (clk),
          .rst      (rst),
          .i_raw    (bus.key_raw[i]),
          .o_level  (bus.key_level[i]),
          .o_press  (bus.key_press[i]),
          .o_release(bus.key_release[i])
`ifdef KEY_LONG_PRESS_EN
          ,
          .o_long   (bus.key_long[i])
`endif
        );
      end
    end else begin : g_bad_cfg
      assign bus.key_level   = '0;
      assign bus.key_press   = '0;
      assign bus.key_release = '0;
`ifdef KEY_LONG_PRESS_EN
      assign bus.key_long    = '0;
`endif
    end
  endgenerate

endmodule
